// File: rtl/pipe_skid_stage_pkg.sv
// Shared definitions for the elastic pipeline stage: state encoding,
// the ISA NOP bubble, and the squash-count helper.
package pipe_skid_stage_pkg;

  // Encoding doubles as the occupancy count (EMPTY=0, ONE=1, TWO=2).
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // addi x0, x0, 0: the canonical RISC-V NOP used as a pipeline bubble.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Entries lost to a flush: everything held, minus the one that leaves
  // on the output side in the same cycle (downstream owns it).
  function automatic logic [1:0] squash_amount(input state_e st, input logic pop);
    logic [1:0] held;
    case (st)
      ST_EMPTY: held = 2'd0;
      ST_ONE:   held = 2'd1;
      ST_TWO:   held = 2'd2;
      default:  held = 2'd0;
    endcase
    if (pop && (held != 2'd0)) begin
      squash_amount = held - 2'd1;
    end else begin
      squash_amount = held;
    end
  endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline register with a 2-entry skid buffer. in_ready and
// out_valid are pure decodes of the state register, so neither has a
// combinational path from the downstream handshake. Flush squashes all
// held entries and counts the ones that never reached downstream.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int              WIDTH        = 32,
  parameter logic [WIDTH-1:0] BUBBLE      = {WIDTH{1'b0}},
  parameter bit              CLEAR_ON_POP = 1'b1,
  parameter int              CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] squash_cnt
);

  localparam logic [CNT_W+1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

  state_e             state_r;
  state_e             state_nxt_s;
  logic [WIDTH-1:0]   main_r;
  logic [WIDTH-1:0]   main_nxt_s;
  logic [WIDTH-1:0]   skid_r;
  logic [WIDTH-1:0]   skid_nxt_s;
  logic [CNT_W-1:0]   squash_cnt_r;
  logic [CNT_W-1:0]   squash_cnt_nxt_s;
  logic [CNT_W+1:0]   cnt_sum_s;
  logic               pop_s;

  assign out_valid  = (state_r != ST_EMPTY);
  assign in_ready   = (state_r != ST_TWO);
  assign occupancy  = state_r;
  assign out_data   = main_r;
  assign squash_cnt = squash_cnt_r;
  assign pop_s      = out_valid & out_ready;

  // State, data registers and squash counter; reset discards everything uncounted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_EMPTY;
      main_r       <= BUBBLE;
      skid_r       <= BUBBLE;
      squash_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      main_r       <= main_nxt_s;
      skid_r       <= skid_nxt_s;
      squash_cnt_r <= squash_cnt_nxt_s;
    end
  end

  // Next-state, data movement and saturating squash count; flush overrides the handshake.
  always_comb begin
    state_nxt_s      = state_r;
    main_nxt_s       = main_r;
    skid_nxt_s       = skid_r;
    squash_cnt_nxt_s = squash_cnt_r;
    cnt_sum_s        = {2'b00, squash_cnt_r}
                     + {{CNT_W{1'b0}}, squash_amount(state_r, pop_s)};

    if (flush) begin
      state_nxt_s = ST_EMPTY;
      main_nxt_s  = BUBBLE;
      skid_nxt_s  = BUBBLE;
      if (cnt_sum_s > CNT_MAX) begin
        squash_cnt_nxt_s = {CNT_W{1'b1}};
      end else begin
        squash_cnt_nxt_s = cnt_sum_s[CNT_W-1:0];
      end
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_valid) begin
            main_nxt_s  = in_data;
            state_nxt_s = ST_ONE;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_valid && out_ready) begin
            main_nxt_s = in_data;
          end else if (in_valid) begin
            skid_nxt_s  = in_data;
            state_nxt_s = ST_TWO;
          end else if (out_ready) begin
            state_nxt_s = ST_EMPTY;
            if (CLEAR_ON_POP) begin
              main_nxt_s = BUBBLE;
            end else begin
              main_nxt_s = main_r;
            end
          end else begin
            state_nxt_s = ST_ONE;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so in_data is never looked at.
          if (out_ready) begin
            main_nxt_s  = skid_r;
            skid_nxt_s  = BUBBLE;
            state_nxt_s = ST_ONE;
          end else begin
            state_nxt_s = ST_TWO;
          end
        end
        default: begin
          state_nxt_s = ST_EMPTY;
          main_nxt_s  = BUBBLE;
          skid_nxt_s  = BUBBLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage. Instance A (default counter,
// clear-on-pop) is checked through a scoreboard queue filled by the
// stimulus and drained by a monitor on every output transfer. Instance B
// (2-bit counter, hold-on-pop) covers saturation and data retention.
module tb_pipe_skid_stage;
  import pipe_skid_stage_pkg::*;

  localparam logic [31:0] BUB = NOP_INSTR;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic [31:0] a_in_data = 32'h0;
  logic        a_in_ready, a_out_valid;
  logic [31:0] a_out_data;
  logic [1:0]  a_occupancy;
  logic [7:0]  a_squash_cnt;

  logic        b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic [31:0] b_in_data = 32'h0;
  logic        b_in_ready, b_out_valid;
  logic [31:0] b_out_data;
  logic [1:0]  b_occupancy;
  logic [1:0]  b_squash_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  pipe_skid_stage #(.WIDTH(32), .BUBBLE(BUB), .CLEAR_ON_POP(1'b1), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .occupancy(a_occupancy), .squash_cnt(a_squash_cnt)
  );

  pipe_skid_stage #(.WIDTH(32), .BUBBLE(BUB), .CLEAR_ON_POP(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .occupancy(b_occupancy), .squash_cnt(b_squash_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard monitor: every output transfer of instance A must match the queue head.
  always @(negedge clk) begin
    if (!rst && a_out_valid && a_out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: got %h, expected no transfer", a_out_data);
      end else begin
        check("sb_data", a_out_data, exp_q.pop_front());
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    tick(); tick();
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_in_ready",  32'(a_in_ready),  32'd1);
    check("rst_out_data",  a_out_data,       BUB);
    check("rst_occupancy", 32'(a_occupancy), 32'd0);
    check("rst_squash",    32'(a_squash_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // Streaming 1..8 at full rate
    a_out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 32'(i);
      exp_q.push_back(32'(i));
      tick();
      check("stream_occ", 32'(a_occupancy), 32'd1);
    end
    a_in_valid = 1'b0;
    tick();
    check("drain_occ",  32'(a_occupancy), 32'd0);
    check("drain_data", a_out_data,       BUB);

    // Stall into the skid entry, then release
    a_in_valid = 1'b1; a_in_data = 32'hA; exp_q.push_back(32'hA);
    tick();
    a_in_data = 32'hB; a_out_ready = 1'b0; exp_q.push_back(32'hB);
    tick();
    a_in_valid = 1'b0;
    check("skid_occ",      32'(a_occupancy), 32'd2);
    check("skid_in_ready", 32'(a_in_ready),  32'd0);
    check("skid_head",     a_out_data,       32'hA);
    tick();
    check("stall_hold_occ", 32'(a_occupancy), 32'd2);
    a_out_ready = 1'b1;
    tick();
    check("pop_in_ready", 32'(a_in_ready),  32'd1);
    check("pop_occ",      32'(a_occupancy), 32'd1);
    check("pop_data",     a_out_data,       32'hB);
    tick();
    check("pop2_occ", 32'(a_occupancy), 32'd0);

    // Flush while stalled with two entries
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 32'hC1;
    tick();
    a_in_data = 32'hC2;
    tick();
    check("fs_fill_occ", 32'(a_occupancy), 32'd2);
    a_in_data = 32'hDEAD; a_flush = 1'b1;
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0;
    check("fs_occ",       32'(a_occupancy),  32'd0);
    check("fs_out_valid", 32'(a_out_valid),  32'd0);
    check("fs_data",      a_out_data,        BUB);
    check("fs_squash",    32'(a_squash_cnt), 32'd2);

    // Flush with pop: held word delivered, incoming dropped
    a_in_valid = 1'b1; a_in_data = 32'hD; exp_q.push_back(32'hD);
    tick();
    a_in_data = 32'hE; a_out_ready = 1'b1; a_flush = 1'b1;
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    check("fp_occ",    32'(a_occupancy),  32'd0);
    check("fp_squash", 32'(a_squash_cnt), 32'd2);
    check("fp_data",   a_out_data,        BUB);

    // Flush with two held and a pop: one delivered, one squashed
    a_in_valid = 1'b1; a_in_data = 32'hF1; exp_q.push_back(32'hF1);
    tick();
    a_in_data = 32'hF2;
    tick();
    a_in_valid = 1'b0; a_out_ready = 1'b1; a_flush = 1'b1;
    tick();
    a_flush = 1'b0; a_out_ready = 1'b0;
    check("f2p_occ",    32'(a_occupancy),  32'd0);
    check("f2p_squash", 32'(a_squash_cnt), 32'd3);

    // Saturation on the 2-bit counter: 2,3,3,3,3
    for (int k = 1; k <= 5; k++) begin
      b_in_valid = 1'b1; b_in_data = 32'(k); b_out_ready = 1'b0;
      tick();
      b_in_data = 32'(k + 16);
      tick();
      check("sat_fill_occ", 32'(b_occupancy), 32'd2);
      b_in_valid = 1'b0; b_flush = 1'b1;
      tick();
      b_flush = 1'b0;
      check("sat_cnt", 32'(b_squash_cnt), (k == 1) ? 32'd2 : 32'd3);
    end

    // Hold-on-pop: last word stays visible after draining
    b_in_valid = 1'b1; b_in_data = 32'h55; b_out_ready = 1'b1;
    tick();
    b_in_valid = 1'b0;
    tick();
    check("hold_occ",   32'(b_occupancy), 32'd0);
    check("hold_valid", 32'(b_out_valid), 32'd0);
    check("hold_data",  b_out_data,       32'h55);
    b_out_ready = 1'b0;

    // Async reset with two entries held
    a_in_valid = 1'b1; a_in_data = 32'h77;
    tick();
    a_in_data = 32'h78;
    tick();
    a_in_valid = 1'b0;
    check("ar_fill_occ", 32'(a_occupancy), 32'd2);
    #1 rst = 1'b1;
    #1;
    check("ar_out_valid", 32'(a_out_valid),  32'd0);
    check("ar_in_ready",  32'(a_in_ready),   32'd1);
    check("ar_out_data",  a_out_data,        BUB);
    check("ar_occ",       32'(a_occupancy),  32'd0);
    check("ar_squash",    32'(a_squash_cnt), 32'd0);
    check("ar_squash_b",  32'(b_squash_cnt), 32'd0);
    rst = 1'b0;
    tick();
    check("ar_after_occ", 32'(a_occupancy), 32'd0);

    check("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
